serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder_digit_add.sv | 17 +
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width; never narrower than one bit, even for a single digit.
  function automatic int cnt_width(input int ndig);
    int w;
    w = $clog2(ndig);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_digit_add.sv
// Combinational DIGIT-bit adder slice: {o_co, o_s} = i_x + i_y + i_ci.
module digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co
);

  logic [DIGIT:0] w_res;

  assign w_res       = {1'b0, i_x} + {1'b0, i_y} + {{DIGIT{1'b0}}, i_ci};
  assign {o_co, o_s} = w_res;

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: {cout, sum} = a + b + cin, DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus,
  output state_t         o_dbg_state
);

  localparam int            NDIG = WIDTH / DIGIT;
  localparam int            CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and the payload is held stable
  // while valid is high and ready is low.
  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_d;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  digit_add #(.DIGIT(DIGIT)) u_digit (
    .i_x  (r_a_sh[DIGIT-1:0]),
    .i_y  (r_b_sh[DIGIT-1:0]),
    .i_ci (r_carry),
    .o_s  (w_d),
    .o_co (w_co)
  );

  // Each new digit enters at the top so the LSB digit ends up at bit 0.
  generate
    if (NDIG == 1) begin : g_one_digit
      assign w_sum_next = w_d;
    end else begin : g_multi_digit
      assign w_sum_next = {w_d, r_sum_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  logic w_c_into_msb;

  // Carry into the sign bit, recovered from the sign-bit operands and sum bit.
  assign w_c_into_msb = r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1] ^ w_d[DIGIT-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= bus.b;
            r_carry    <= bus.cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum_sh <= w_sum_next;
          r_carry  <= w_co;
          r_a_sh   <= r_a_sh >> DIGIT;
          r_b_sh   <= r_b_sh >> DIGIT;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf       <= w_c_into_msb ^ w_co;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // sum_sh and carry only move in RUN, so the result is frozen throughout DONE.
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum_sh;
  assign bus.cout      = r_carry;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = r_ovf;
`endif
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three 8-bit builds (DIGIT 1/4/8) share one
// stimulus, plus a 4-bit DIGIT=2 instance swept over every operand combination.
module tb_serial_adder;
  import serial_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic       in_valid, cin, out_ready;
  logic [7:0] a, b;

  serial_adder_if #(.WIDTH(8)) s1 ();
  serial_adder_if #(.WIDTH(8)) s4 ();
  serial_adder_if #(.WIDTH(8)) s8 ();
  serial_adder_if #(.WIDTH(4)) sq ();

  assign {s1.in_valid, s1.a, s1.b, s1.cin, s1.out_ready} = {in_valid, a, b, cin, out_ready};
  assign {s4.in_valid, s4.a, s4.b, s4.cin, s4.out_ready} = {in_valid, a, b, cin, out_ready};
  assign {s8.in_valid, s8.a, s8.b, s8.cin, s8.out_ready} = {in_valid, a, b, cin, out_ready};

  state_t st1, st4, st8, stq;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(s1), .o_dbg_state(st1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(s4), .o_dbg_state(st4));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(s8), .o_dbg_state(st8));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u_q  (.clk(clk), .rst(rst), .bus(sq), .o_dbg_state(stq));

  logic [3:0] g_s;
  logic       g_co;
  digit_add #(.DIGIT(4)) u_gold (.i_x(sq.a), .i_y(sq.b), .i_ci(sq.cin), .o_s(g_s), .o_co(g_co));

  logic       ov[3];
  logic       ir[3];
  logic       co[3];
  logic [7:0] sm[3];
  assign {ov[0], ir[0], co[0], sm[0]} = {s1.out_valid, s1.in_ready, s1.cout, s1.sum};
  assign {ov[1], ir[1], co[1], sm[1]} = {s4.out_valid, s4.in_ready, s4.cout, s4.sum};
  assign {ov[2], ir[2], co[2], sm[2]} = {s8.out_valid, s8.in_ready, s8.cout, s8.sum};
`ifdef SERIAL_ADD_OVF_EN
  logic of[3];
  assign of[0] = s1.ovf;
  assign of[1] = s4.ovf;
  assign of[2] = s8.ovf;
`endif

  localparam int NDIGS[3] = '{8, 2, 1};

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vt[10];

  // ---------------- driver ----------------
  // Issue one operation to the three 8-bit builds with out_ready high and
  // check latency and result of each; operands are scrambled after accept.
  task automatic run_op(input vec_t v);
    int         lat[3];
    logic [7:0] rs[3];
    logic       rc[3];
    logic       ro[3];
    for (int j = 0; j < 3; j++) begin
      lat[j] = 0; rs[j] = '0; rc[j] = 1'b0; ro[j] = 1'b0;
    end
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    check({v.name, " in_ready"}, {29'd0, ir[0], ir[1], ir[2]}, 32'h7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        if (ov[j] && lat[j] == 0) begin
          lat[j] = n; rs[j] = sm[j]; rc[j] = co[j];
`ifdef SERIAL_ADD_OVF_EN
          ro[j] = of[j];
`endif
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      check($sformatf("%s d%0d latency", v.name, j), 32'(lat[j]), 32'(NDIGS[j]));
      check($sformatf("%s d%0d sum", v.name, j), 32'(rs[j]), 32'(v.sum));
      check($sformatf("%s d%0d cout", v.name, j), 32'(rc[j]), 32'(v.cout));
`ifdef SERIAL_ADD_OVF_EN
      check($sformatf("%s d%0d ovf", v.name, j), 32'(ro[j]), 32'(v.ovf));
`endif
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t       v;
    logic       got;
    logic       any_v;
    logic       acc;
    logic [8:0] iv;
    int         idx;
    int         ndone;
    logic [4:0] e;

    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_p_01"};
    vt[1] = '{8'h37, 8'h48, 1'b1, 8'h80, 1'b0, 1'b1, "37_p_48_c"};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_p_01"};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero"};
    vt[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "cin_only"};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff_p_ff_c"};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80_p_80"};
    vt[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, "a5_p_5a"};
    vt[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "12_p_34_c"};
    vt[9] = '{8'hC3, 8'h96, 1'b0, 8'h59, 1'b1, 1'b1, "c3_p_96"};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    sq.in_valid = 1'b0; sq.a = '0; sq.b = '0; sq.cin = 1'b0; sq.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst d1 state", 32'(st1), 32'(IDLE));
    check("rst d1 in_ready", 32'(ir[0]), 32'd1);
    check("rst d1 out_valid", 32'(ov[0]), 32'd0);
    check("rst d1 sum/cout", {23'd0, co[0], sm[0]}, 32'd0);
    check("rst q state", 32'(stq), 32'(IDLE));
    check("rst q ready/valid", {30'd0, sq.in_ready, sq.out_valid}, 32'h2);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) run_op(vt[i]);

    // Backpressure: hold result in DONE, then release and re-issue
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; cin = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = ov[0];
    end
    check("bp reach done", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold %0d", k), {22'd0, ov[0], ir[0], co[0], sm[0]}, {22'd0, 2'b10, 1'b0, 8'h8D});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release state", 32'(st1), 32'(IDLE));
    check("bp release ready/valid", {30'd0, ir[0], ov[0]}, 32'h2);
    @(posedge clk); #1;
    check("bp reissue state", 32'(st1), 32'(RUN));
    check("bp reissue in_ready", 32'(ir[0]), 32'd0);
    in_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = ov[0];
    end
    check("bp second valid", 32'(got), 32'd1);
    check("bp second result", {23'd0, co[0], sm[0]}, 32'h033);
    repeat (12) @(posedge clk);

    // Reset mid-RUN at cnt=3
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst running", 32'(st1), 32'(RUN));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst state", 32'(st1), 32'(IDLE));
    check("midrst out_valid", 32'(ov[0]), 32'd0);
    check("midrst sum/cout", {23'd0, co[0], sm[0]}, 32'd0);
    check("midrst in_ready", 32'(ir[0]), 32'd1);
    any_v = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      any_v = any_v | ov[0];
    end
    check("midrst no partial valid", 32'(any_v), 32'd0);
    v = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "post_rst"};
    run_op(v);

    // Exhaustive 4-bit sweep with in_valid held continuously
    idx = 0; ndone = 0;
    iv = 9'(idx);
    sq.a = iv[3:0]; sq.b = iv[7:4]; sq.cin = iv[8];
    sq.in_valid = 1'b1; sq.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4000 && ndone < 512; cyc++) begin
      @(negedge clk);
      if (sq.out_valid) begin
        if (exp_q.size() == 0) begin
          check("sweep unexpected result", {27'd0, sq.cout, sq.sum}, 32'h1F_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sweep result %0d", ndone), {27'd0, sq.cout, sq.sum}, {27'd0, e});
        end
        ndone++;
      end
      acc = sq.in_ready && sq.in_valid;
      if (acc) begin
        e = {1'b0, sq.a} + {1'b0, sq.b} + {4'd0, sq.cin};
        exp_q.push_back(e);
        check($sformatf("gold digit_add %0d", idx), {27'd0, g_co, g_s}, {27'd0, e});
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 512) begin
          iv = 9'(idx);
          sq.a = iv[3:0]; sq.b = iv[7:4]; sq.cin = iv[8];
        end else begin
          sq.in_valid = 1'b0;
        end
      end
    end
    check("sweep completed", 32'(ndone), 32'd512);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
